// File: rtl/rgb_bit_depth_reducer_pkg.sv
// Shared constants and types for the RGB bit-depth reducer.
// Holds the dither LFSR constants, the sideband bundle and the rounding setup.
package rgb_bit_depth_reducer_pkg;

  localparam int unsigned LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 of a left-shifting Fibonacci LFSR
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic last;
    logic user;
    logic dest;
    logic id;
  } side_t;

  typedef struct packed {
    int unsigned d;
    int unsigned k;
  } round_cfg_t;

  // d = dropped LSBs, k = half-LSB rounding offset
  function automatic round_cfg_t round_cfg(
    input int unsigned in_w,
    input int unsigned out_w
  );
    round_cfg_t c;
    c.d = (in_w > out_w) ? in_w - out_w : 0;
    c.k = (c.d == 0) ? 0 : (32'd1 << (c.d - 1));
    return c;
  endfunction

endpackage

// File: rtl/rgb_bit_depth_reducer_if.sv
// AXI4-Stream video bundle used on both sides of the reducer.
// master drives tvalid/tdata/sideband and samples tready; slave the reverse.
interface rgb_bit_depth_reducer_if #(
  parameter int DATA_W = 32
) ();

  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic [DATA_W/8-1:0] tstrb;
  logic [DATA_W/8-1:0] tkeep;
  logic              tlast;
  logic              tuser;
  logic              tdest;
  logic              tid;

  modport master (
    output tvalid, tdata, tstrb, tkeep,
    output tlast, tuser, tdest, tid,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep,
    input  tlast, tuser, tdest, tid,
    output tready
  );

endinterface

// File: rtl/rgb_channel_rounder.sv
// One colour channel: add rounding offset (stage 1), shift and saturate (stage 2).
// Ports: clk/rst, en1/en2 stage loads, x input pixel, k offset, y output pixel.
module rgb_channel_rounder #(
  parameter int IN_W  = 10,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en1,
  input  logic             en2,
  input  logic [IN_W-1:0]  x,
  input  logic [IN_W-1:0]  k,
  output logic [OUT_W-1:0] y
);

  localparam int D = IN_W - OUT_W;

  logic [IN_W:0]    s_q;
  logic [IN_W:0]    sh;
  logic [OUT_W-1:0] y_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q <= '0;
    end else if (en1) begin
      s_q <= {1'b0, x} + {1'b0, k};
    end
  end

  assign sh  = s_q >> D;
  // Any bit at or above OUT_W means the rounded value overflowed
  assign y_d = (|sh[IN_W:OUT_W]) ? '1 : sh[OUT_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y <= '0;
    end else if (en2) begin
      y <= y_d;
    end
  end

endmodule

// File: rtl/rgb_bit_depth_reducer.sv
// Packed RGB AXI4-Stream bit-depth reducer, round-half-up with saturation.
// Ports: clk_i, rst_i (async high), video_i (slave), video_o (master). Macro: RGB_BIT_DEPTH_REDUCER_DITHER_EN.
module rgb_bit_depth_reducer
  import rgb_bit_depth_reducer_pkg::*;
#(
  parameter int IN_PX_WIDTH      = 10,
  parameter int OUT_PX_WIDTH     = 8,
  parameter int RX_TDATA_WIDTH   = ((IN_PX_WIDTH * 3 + 7) / 8) * 8,
  parameter int TX_TDATA_WIDTH   = ((OUT_PX_WIDTH * 3 + 7) / 8) * 8,
  parameter int RX_TDATA_WIDTH_B = RX_TDATA_WIDTH / 8,
  parameter int TX_TDATA_WIDTH_B = TX_TDATA_WIDTH / 8
) (
  input  logic clk_i,
  input  logic rst_i,
  rgb_bit_depth_reducer_if.slave  video_i,
  rgb_bit_depth_reducer_if.master video_o
);

  if (OUT_PX_WIDTH > IN_PX_WIDTH) begin : g_bad_cfg
    $error("OUT_PX_WIDTH must not exceed IN_PX_WIDTH");
  end

  localparam round_cfg_t CFG = round_cfg(IN_PX_WIDTH, OUT_PX_WIDTH);
  localparam int D = int'(CFG.d);

  logic s1_valid;
  logic s2_valid;
  logic s1_adv;
  logic s2_adv;
  logic in_fire;
  side_t in_side;
  side_t s1_side;
  side_t s2_side;
  logic [IN_PX_WIDTH-1:0]  k_val;
  logic [OUT_PX_WIDTH-1:0] y [3];
  logic [TX_TDATA_WIDTH-1:0] tx_data;
  logic unused_in;

  assign s2_adv  = !s2_valid || video_o.tready;
  assign s1_adv  = !s1_valid || s2_adv;
  assign video_i.tready = s1_adv && !rst_i;
  assign in_fire = video_i.tvalid && video_i.tready;

  assign in_side = '{
    last: video_i.tlast,
    user: video_i.tuser,
    dest: video_i.tdest,
    id:   video_i.tid
  };

  assign unused_in = ^{video_i.tstrb, video_i.tkeep, video_i.tdata};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_side  <= '0;
      s2_side  <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_fire;
        if (in_fire) s1_side <= in_side;
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_side <= s1_side;
      end
    end
  end

`ifdef RGB_BIT_DEPTH_REDUCER_DITHER_EN
  if (D > 0) begin : g_dither
    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_cur;

    // A start-of-frame beat restarts the sequence and uses the seed itself
    assign lfsr_cur = video_i.tuser ? LFSR_SEED : lfsr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        lfsr_q <= LFSR_SEED;
      end else if (in_fire) begin
        lfsr_q <= {lfsr_cur[LFSR_W-2:0], ^(lfsr_cur & LFSR_TAPS)};
      end
    end

    always_comb begin
      k_val = '0;
      k_val[D-1:0] = lfsr_cur[D-1:0];
    end
  end else begin : g_no_dither
    assign k_val = '0;
  end
`else
  assign k_val = IN_PX_WIDTH'(CFG.k);
`endif

  for (genvar c = 0; c < 3; c++) begin : g_ch
    rgb_channel_rounder #(
      .IN_W  (IN_PX_WIDTH),
      .OUT_W (OUT_PX_WIDTH)
    ) u_rnd (
      .clk (clk_i),
      .rst (rst_i),
      .en1 (in_fire),
      .en2 (s2_adv && s1_valid),
      .x   (video_i.tdata[c*IN_PX_WIDTH +: IN_PX_WIDTH]),
      .k   (k_val),
      .y   (y[c])
    );
  end

  always_comb begin
    tx_data = '0;
    for (int c = 0; c < 3; c++) begin
      tx_data[c*OUT_PX_WIDTH +: OUT_PX_WIDTH] = y[c];
    end
  end

  assign video_o.tvalid = s2_valid;
  assign video_o.tdata  = tx_data;
  assign video_o.tstrb  = '1;
  assign video_o.tkeep  = '1;
  assign video_o.tlast  = s2_side.last;
  assign video_o.tuser  = s2_side.user;
  assign video_o.tdest  = s2_side.dest;
  assign video_o.tid    = s2_side.id;

endmodule

// File: tb/tb_rgb_bit_depth_reducer.sv
// Scoreboard bench for rgb_bit_depth_reducer: 10->8 instance and 8->8 pass-through.
// Stimulus pushes expected beats; negedge monitors pop and compare.
module tb_rgb_bit_depth_reducer;

`ifdef RGB_BIT_DEPTH_REDUCER_DITHER_EN
  localparam bit DITH = 1'b1;
`else
  localparam bit DITH = 1'b0;
`endif

  typedef struct {
    logic [23:0] data;
    logic [3:0]  side;
    int          cyc;
    bit          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rgb_bit_depth_reducer_if #(.DATA_W(32)) vi ();
  rgb_bit_depth_reducer_if #(.DATA_W(24)) vo ();
  rgb_bit_depth_reducer_if #(.DATA_W(24)) vi8 ();
  rgb_bit_depth_reducer_if #(.DATA_W(24)) vo8 ();

  rgb_bit_depth_reducer #(
    .IN_PX_WIDTH  (10),
    .OUT_PX_WIDTH (8)
  ) u_dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .video_i (vi),
    .video_o (vo)
  );

  rgb_bit_depth_reducer #(
    .IN_PX_WIDTH  (8),
    .OUT_PX_WIDTH (8)
  ) u_dut8 (
    .clk_i   (clk),
    .rst_i   (rst),
    .video_i (vi8),
    .video_o (vo8)
  );

  exp_t q10[$];
  exp_t q8[$];
  int n_chk = 0;
  int n_fail = 0;
  int ncyc = 0;
  bit rnd = 1'b0;
  logic rdy_fix = 1'b1;
  logic [15:0] lfsr_m = 16'hACE1;

  always @(posedge clk) ncyc <= ncyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] px(logic [9:0] x, logic [9:0] k);
    logic [10:0] s;
    s = ({1'b0, x} + {1'b0, k}) >> 2;
    return (s > 11'h0FF) ? 8'hFF : s[7:0];
  endfunction

  function automatic logic [15:0] lfsr_step(logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Output ready driver for the 10->8 instance
  initial begin
    vo.tready = 1'b1;
    vo8.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      vo.tready = rnd ? 1'($urandom_range(0, 1)) : rdy_fix;
    end
  end

  // Monitor for the 10->8 instance
  logic prev_stall = 1'b0;
  logic [23:0] prev_data;
  logic [3:0]  prev_side;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(vo.tvalid), 32'd1);
        chk("hold_data", 32'(vo.tdata), 32'(prev_data));
        chk("hold_side", 32'({vo.tlast, vo.tuser, vo.tdest, vo.tid}),
            32'(prev_side));
      end
      if (vo.tvalid && vo.tready) begin
        chk("strb_keep", 32'({vo.tstrb, vo.tkeep}), 32'h3F);
        if (q10.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_beat: got %0h expected none", vo.tdata);
        end else begin
          exp_t e;
          e = q10.pop_front();
          chk("data", 32'(vo.tdata), 32'(e.data));
          chk("side", 32'({vo.tlast, vo.tuser, vo.tdest, vo.tid}),
              32'(e.side));
          if (e.lat) chk("latency", 32'(ncyc), 32'(e.cyc));
        end
      end
      prev_stall = vo.tvalid && !vo.tready;
      prev_data  = vo.tdata;
      prev_side  = {vo.tlast, vo.tuser, vo.tdest, vo.tid};
    end
  end

  // Monitor for the 8->8 instance
  always @(negedge clk) begin
    if (!rst && vo8.tvalid && vo8.tready) begin
      if (q8.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_beat8: got %0h expected none", vo8.tdata);
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("data8", 32'(vo8.tdata), 32'(e.data));
        chk("side8", 32'({vo8.tlast, vo8.tuser, vo8.tdest, vo8.tid}),
            32'(e.side));
        if (e.lat) chk("latency8", 32'(ncyc), 32'(e.cyc));
      end
    end
  end

  task automatic send10(
    input logic [9:0]  r,
    input logic [9:0]  g,
    input logic [9:0]  b,
    input logic [3:0]  side,
    input logic [23:0] hand,
    input bit          use_hand,
    input bit          lat
  );
    bit ok;
    exp_t e;
    logic [9:0] kk;
    ok = 1'b0;
    vi.tvalid = 1'b1;
    vi.tdata  = {2'b00, b, g, r};
    {vi.tlast, vi.tuser, vi.tdest, vi.tid} = side;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (vi.tready) begin
        ok = 1'b1;
        if (DITH) begin
          kk = {8'd0, (side[2] ? 2'b01 : lfsr_m[1:0])};
          lfsr_m = lfsr_step(side[2] ? 16'hACE1 : lfsr_m);
        end else begin
          kk = 10'd2;
        end
        e.data = use_hand ? hand : {px(b, kk), px(g, kk), px(r, kk)};
        e.side = side;
        e.cyc  = ncyc + 2;
        e.lat  = lat;
        q10.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    vi.tvalid = 1'b0;
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: got no tready expected tready");
    end
  endtask

  task automatic send8(input logic [23:0] d, input logic [3:0] side);
    bit ok;
    exp_t e;
    ok = 1'b0;
    vi8.tvalid = 1'b1;
    vi8.tdata  = d;
    {vi8.tlast, vi8.tuser, vi8.tdest, vi8.tid} = side;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (vi8.tready) begin
        ok = 1'b1;
        e.data = d;
        e.side = side;
        e.cyc  = ncyc + 2;
        e.lat  = 1'b1;
        q8.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    vi8.tvalid = 1'b0;
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL send8_timeout: got no tready expected tready");
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 2000 && (q10.size() != 0 || q8.size() != 0); t++)
      @(posedge clk);
    if (q10.size() != 0 || q8.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               q10.size() + q8.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    vi.tvalid = 1'b0;
    vi.tdata = '0;
    vi.tstrb = '0;
    vi.tkeep = '0;
    {vi.tlast, vi.tuser, vi.tdest, vi.tid} = 4'b0;
    vi8.tvalid = 1'b0;
    vi8.tdata = '0;
    vi8.tstrb = '0;
    vi8.tkeep = '0;
    {vi8.tlast, vi8.tuser, vi8.tdest, vi8.tid} = 4'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", 32'(vo.tvalid), 32'd0);
    chk("rst_tdata", 32'(vo.tdata), 32'd0);
    chk("rst_side", 32'({vo.tlast, vo.tuser, vo.tdest, vo.tid}), 32'd0);
    chk("rst_in_ready", 32'(vi.tready), 32'd0);
    rst = 1'b0;
    lfsr_m = 16'hACE1;
    #1;
    chk("in_ready_after_rst", 32'(vi.tready), 32'd1);
    @(posedge clk);
    #1;

    // 1: rounding and saturation, latency
    send10(10'h3FF, 10'h201, 10'h202, 4'b0000, 24'h8180FF, !DITH, 1'b1);
    drain();

    // 2: random backpressure stream
    rnd = 1'b1;
    for (int i = 0; i < 64; i++) begin
      send10(10'($urandom), 10'($urandom), 10'($urandom),
             4'($urandom_range(0, 15)), 24'd0, 1'b0, 1'b0);
    end
    drain();
    rnd = 1'b0;
    rdy_fix = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 3: one line with sideband
    for (int i = 0; i < 8; i++) begin
      send10(10'(i * 97), 10'(1023 - i * 61), 10'(i * 130 + 1),
             {(i == 7), (i == 0), 2'b11}, 24'd0, 1'b0, 1'b0);
    end
    drain();

    // 4: reset with two beats stuck in the pipe
    rdy_fix = 1'b0;
    @(posedge clk);
    #1;
    send10(10'h010, 10'h020, 10'h030, 4'b0000, 24'd0, 1'b0, 1'b0);
    send10(10'h040, 10'h050, 10'h060, 4'b0000, 24'd0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("stall_tvalid", 32'(vo.tvalid), 32'd1);
    chk("stall_in_ready", 32'(vi.tready), 32'd0);
    rst = 1'b1;
    #1;
    chk("async_rst_tvalid", 32'(vo.tvalid), 32'd0);
    chk("rst_in_ready_mid", 32'(vi.tready), 32'd0);
    q10.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
    lfsr_m = 16'hACE1;
    #1;
    chk("post_rst_in_ready", 32'(vi.tready), 32'd1);
    chk("post_rst_tvalid", 32'(vo.tvalid), 32'd0);
    rdy_fix = 1'b1;
    @(posedge clk);
    #1;
    send10(10'h100, 10'h0FF, 10'h003, 4'b0000, 24'h014040, !DITH, 1'b1);
    drain();

    // 5: 8->8 pass-through
    send8(24'h000000, 4'b0100);
    send8(24'hFFFFFF, 4'b0011);
    send8(24'h00FF00, 4'b0000);
    send8(24'h123456, 4'b1000);
    drain();

    // 6: dither restart on start of frame
    if (DITH) begin
      send10(10'h002, 10'h002, 10'h002, 4'b0100, 24'h000000, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) begin
        send10(10'h002 + 10'(i), 10'h1FE, 10'h3FD, 4'b0000, 24'd0,
               1'b0, 1'b0);
      end
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rgb_bit_depth_reducer.md
Name: rgb_bit_depth_reducer

Overview:
Downstream neighbour of the grayscale-to-RGB adapter. Consumes packed 3-channel AXI4-Stream video at IN_PX_WIDTH bits per channel and emits the same stream at OUT_PX_WIDTH bits per channel, using round-half-up and saturation. Typical use is 10-bit RGB into 8-bit RGB ahead of display and DMA sinks. The datapath is a 2-stage pipeline with full AXI4-Stream backpressure support.

Parameters:
IN_PX_WIDTH, 10, input bits per channel.
OUT_PX_WIDTH, 8, output bits per channel. Must satisfy OUT_PX_WIDTH <= IN_PX_WIDTH; elaboration error otherwise.
RX_TDATA_WIDTH, IN_PX_WIDTH*3 rounded up to a multiple of 8, input tdata width.
TX_TDATA_WIDTH, OUT_PX_WIDTH*3 rounded up to a multiple of 8, output tdata width.
RX_TDATA_WIDTH_B, RX_TDATA_WIDTH/8, input strobe/keep width.
TX_TDATA_WIDTH_B, TX_TDATA_WIDTH/8, output strobe/keep width.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-high
video_i_tvalid  in  1  input beat valid
video_i_tdata  in  RX_TDATA_WIDTH  channel c at [c*IN_PX_WIDTH +: IN_PX_WIDTH], c=0..2; padding bits ignored
video_i_tlast  in  1  end of line
video_i_tstrb  in  RX_TDATA_WIDTH_B  ignored
video_i_tkeep  in  RX_TDATA_WIDTH_B  ignored
video_i_tuser  in  1  start of frame
video_i_tdest  in  1  passed through
video_i_tid  in  1  passed through
video_i_tready  out  1  input ready
video_o_tvalid  out  1  output beat valid
video_o_tdata  out  TX_TDATA_WIDTH  channel c at [c*OUT_PX_WIDTH +: OUT_PX_WIDTH]; padding bits driven 0
video_o_tlast  out  1  aligned with its data
video_o_tstrb  out  TX_TDATA_WIDTH_B  all ones
video_o_tkeep  out  TX_TDATA_WIDTH_B  all ones
video_o_tuser  out  1  aligned with its data
video_o_tdest  out  1  aligned with its data
video_o_tid  out  1  aligned with its data
video_o_tready  in  1  downstream ready

Behaviour:
- Reset (rst_i high, asynchronous):
  - both stage valid flags clear; all data and sideband registers 0; video_o_tvalid = 0.
  - video_i_tready is forced to 0 while rst_i is high.
- Per channel, with D = IN_PX_WIDTH - OUT_PX_WIDTH:
  - stage 1 registers s = x + K in IN_PX_WIDTH+1 bits, where K = 2^(D-1) (K = 0 when D = 0).
  - stage 2 registers y = s >> D, saturated to 2^OUT_PX_WIDTH - 1 if it overflows.
  - D = 0 gives a pure 2-cycle pass-through.
- Pipeline handshake:
  - stage 2 = output register; it advances when empty or when video_o_tready is high.
  - stage 1 advances when empty or when stage 2 advances.
  - video_i_tready = !s1_valid || s2_advance (combinational from registers and video_o_tready).
- Timing:
  - latency is 2 cycles from the input handshake to video_o_tvalid.
  - throughput is 1 beat/clk while video_o_tready is high.
- Backpressure:
  - output tdata and sideband are held stable while tvalid is high and tready is low.
  - no beat is dropped or duplicated.
  - at most 2 beats are in flight.
- Sideband: tlast, tuser, tdest and tid travel through both stages with their beat; no reordering.
- Simultaneous accept and emit in the same cycle: both happen; occupancy is unchanged.
- Reset mid-frame: in-flight beats are discarded; the first beat after reset is forwarded as-is (no frame resync is imposed).

Optional Feature:
Macro RGB_BIT_DEPTH_REDUCER_DITHER_EN.
- Defined:
  - a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) replaces K with LFSR[D-1:0], using the same value for all 3 channels to avoid chroma noise.
  - the LFSR is reloaded with the seed on an accepted beat with tuser = 1; that beat uses the seed value.
  - the LFSR steps once per accepted beat.
  - reset loads the seed.
  - no effect when D = 0.
- Undefined: no LFSR logic; fixed K rounding only.

Decomposition:
- Package rgb_bit_depth_reducer_pkg holds:
  - the LFSR seed, tap mask and width constant;
  - a function computing D and K from the parameters.
- Sub-module rgb_channel_rounder: one channel's add, shift and saturate with its two registers plus enable. Instantiated ×3. The top owns the valid/ready control, sideband registers and LFSR.

Test Plan:
1. IN=10/OUT=8, tready=1; channels 0x3FF/0x201/0x202 -> 0xFF (saturated)/0x80/0x81; first output beat 2 clk after the input handshake.
2. Stream of 64 beats with a random tready duty (~50%) -> all 64 out in order, values bit-exact to the reference model, tdata stable while stalled.
3. Line of 8 beats, tuser on beat 0 and tlast on beat 7, tdest=1, tid=1 -> same flags on output beats 0 and 7; tdest/tid constant 1.
4. rst_i pulsed for 1 clk with 2 beats in flight and tready=0 -> video_o_tvalid drops asynchronously, both beats are lost, tready returns to 1 after reset, the next beat passes correctly.
5. IN=8/OUT=8 -> output equals input delayed 2 clk; 0x00 and 0xFF are unchanged.
6. DITHER_EN, IN=10/OUT=8: tuser beat with all channels 0x002 -> K = 0xACE1[1:0] = 1 -> output 0x00; later beats match the LFSR-sequence model.
